// File: rtl/adder26_pkg.sv
// Shared widths and types for the adder26 partition.
// The partition is fixed at 3-bit operands with a 4-bit sum.
package adder26_pkg;
  localparam int WIDTH = 3;
  localparam int SUM_W = WIDTH + 1;

  typedef logic [WIDTH-1:0] operand_t;
  typedef logic [SUM_W-1:0] sum_t;
endpackage

// File: rtl/adder26_full_adder.sv
// One-bit full adder cell; chained by the top to form the ripple adder.
module adder26_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/adder26.sv
// Registered A + B + Cin adder partition.
// The sum is valid one cycle after the operands are qualified by in_valid.
module adder26
  import adder26_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic pi6,
  input  logic pi5,
  input  logic pi4,
  input  logic pi3,
  input  logic pi2,
  input  logic pi1,
  input  logic pi0,
  output logic po3,
  output logic po2,
  output logic po1,
  output logic po0,
  output logic out_valid
);
  operand_t       a, b;
  logic [WIDTH:0] c;
  operand_t       s;
  sum_t           sum_d, sum_q;
  logic           vld_q;

  assign a    = {pi6, pi5, pi4};
  assign b    = {pi3, pi2, pi1};
  assign c[0] = pi0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    adder26_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign sum_d = {c[WIDTH], s};

  // The enable gates the load, so undriven operands during idle cycles never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) sum_q <= sum_d;
    end
  end

  assign po3       = sum_q[3];
  assign po2       = sum_q[2];
  assign po1       = sum_q[1];
  assign po0       = sum_q[0];
  assign out_valid = vld_q;
endmodule

// File: tb/tb_adder26.sv
// Directed bench for adder26: reset, corner table, hold/gap, exhaustive sweep with mid-stream reset.
module tb_adder26;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b1;
  logic [6:0] pi = 7'h7f;
  logic       po3, po2, po1, po0, out_valid;
  logic [3:0] po;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [6:0] pi;
    logic [3:0] po;
  } vec_t;

  vec_t vecs[6];

  adder26 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pi6       (pi[6]),
    .pi5       (pi[5]),
    .pi4       (pi[4]),
    .pi3       (pi[3]),
    .pi2       (pi[2]),
    .pi1       (pi[1]),
    .pi0       (pi[0]),
    .po3       (po3),
    .po2       (po2),
    .po1       (po1),
    .po0       (po0),
    .out_valid (out_valid)
  );

  assign po = {po3, po2, po1, po0};

  always #5 clk = ~clk;

  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: po got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: out_valid got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model(input logic [6:0] v);
    return {1'b0, v[6:4]} + {1'b0, v[3:1]} + {3'b000, v[0]};
  endfunction

  // Drive between edges, then sample 1 time unit after the capturing edge.
  task automatic cyc(input logic [6:0] v, input logic iv);
    pi       = v;
    in_valid = iv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"zero",     7'b0000000, 4'b0000};
    vecs[1] = '{"all_ones", 7'b1111111, 4'b1111};
    vecs[2] = '{"cin_only", 7'b0000001, 4'b0001};
    vecs[3] = '{"a_msb",    7'b1000000, 4'b0100};
    vecs[4] = '{"ripple9",  7'b0011111, 4'b1001};
    vecs[5] = '{"three3",   7'b0110110, 4'b0110};

    // Reset asserted with all inputs high and in_valid set.
    #2;
    chk4("reset_po_now", po, 4'b0000);
    chk1("reset_vld_now", out_valid, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk4("reset_po_hold", po, 4'b0000);
    chk1("reset_vld_hold", out_valid, 1'b0);

    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    chk1("post_release_idle", out_valid, 1'b0);

    foreach (vecs[i]) begin
      cyc(vecs[i].pi, 1'b1);
      chk4(vecs[i].name, po, vecs[i].po);
      chk1({vecs[i].name, "_vld"}, out_valid, 1'b1);
    end

    // Hold and gap, including X operands while idle.
    cyc(7'b0101010, 1'b1);
    chk4("hold_load", po, 4'b0111);
    chk1("hold_load_vld", out_valid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(7'b1111111, 1'b0);
      chk4("gap_po", po, 4'b0111);
      chk1("gap_vld", out_valid, 1'b0);
    end
    cyc(7'bxxxxxxx, 1'b0);
    chk4("gap_x_po", po, 4'b0111);
    chk1("gap_x_vld", out_valid, 1'b0);

    // Exhaustive back-to-back sweep with an async reset dropped in the middle.
    for (int i = 0; i < 128; i++) begin
      if (i == 64) begin
        #2 rst_n = 1'b0;
        #1;
        chk4("mid_rst_po_now", po, 4'b0000);
        chk1("mid_rst_vld_now", out_valid, 1'b0);
        @(posedge clk); #1;
        chk4("mid_rst_po_hold", po, 4'b0000);
        chk1("mid_rst_vld_hold", out_valid, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        chk4("mid_rel_po", po, 4'b0000);
        chk1("mid_rel_vld", out_valid, 1'b0);
      end
      cyc(7'(i), 1'b1);
      chk4("exh_po", po, model(7'(i)));
      chk1("exh_vld", out_valid, 1'b1);
    end

    cyc(7'b0000000, 1'b0);
    chk4("final_hold_po", po, model(7'd127));
    chk1("final_vld", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
